// File: rtl/vmem_pkg.sv
// Shared constants, state codes and the R-channel beat record for the framebuffer slave.
package vmem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam int unsigned WORD_BYTES = 8;

    // Controller states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD    = 2'd1;
    localparam logic [1:0] WR    = 2'd2;
    localparam logic [1:0] WRESP = 2'd3;

    // One entry of the R output buffer; rid is constant per burst and kept outside
    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    // FIXED and INCR are served; WRAP and reserved encodings are answered with SLVERR
    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/vmem_axi_if.sv
// AXI4 bus bundle between the crossbar (master) and the framebuffer memory (slave).
interface vmem_axi_if #(
    parameter int ID_W = 4
);
    logic            awvalid;
    logic            awready;
    logic [31:0]     awaddr;
    logic [ID_W-1:0] awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;

    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;

    logic            wvalid;
    logic            wready;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic            wlast;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    logic            rvalid;
    logic            rready;
    logic [63:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

endinterface

// File: rtl/vmem_ram.sv
// Single-port byte-enabled 64-bit RAM with a registered read port.
module vmem_ram
    import vmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 18
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [7:0]            be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [63:0]           wdata,
    output logic [63:0]           rdata
);

    logic [63:0] mem [2**DEPTH_LOG2];

    // Byte-masked write or 1-cycle read; rdata holds its value during write cycles
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/vmem_axi_slave.sv
// AXI4 burst slave in front of the framebuffer RAM; reads and writes share one RAM port.
module vmem_axi_slave #(
    parameter int DEPTH_LOG2 = 18,
    parameter int ID_W       = 4
) (
    input logic      clock,
    input logic      reset,
    vmem_axi_if.slave io_slave
);
    import vmem_pkg::*;

    logic [1:0] state;
    logic       prio_rd;

    // Read burst context
    logic [ID_W-1:0]       rd_id;
    logic [7:0]            rd_len;
    logic [1:0]            rd_burst;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [8:0]            rd_issued;
    logic                  rd_pend;
    logic                  rd_pend_err;
    logic                  rd_pend_last;

    // Two-entry R buffer: out drives the bus, skid absorbs the beat already in flight
    rbeat_t out_beat;
    rbeat_t skid_beat;
    logic   out_valid;
    logic   skid_valid;

    // Write burst context
    logic [ID_W-1:0]       wr_id;
    logic [7:0]            wr_len;
    logic [1:0]            wr_burst;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [8:0]            wr_cnt;
    logic                  wr_overrun;
    logic [1:0]            bresp;

    logic                  ar_hs;
    logic                  aw_hs;
    logic                  pop;
    logic [1:0]            occ_after;
    logic                  rd_issue;
    logic                  issue_err;
    logic                  issue_last;
    logic                  issue_incr;
    logic [DEPTH_LOG2-1:0] issue_addr;
    logic                  wr_beat;
    logic                  wr_we;
    logic                  ram_en;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [63:0]           ram_rdata;
    rbeat_t                in_beat;
    logic                  unused_bits;

    assign unused_bits = ^{io_slave.awsize, io_slave.arsize, io_slave.awaddr, io_slave.araddr};

    assign io_slave.arready = !reset && (state == IDLE) && (!io_slave.awvalid || prio_rd);
    assign io_slave.awready = !reset && (state == IDLE) && (!io_slave.arvalid || !prio_rd);
    assign io_slave.wready  = !reset && (state == WR);
    assign io_slave.bvalid  = !reset && (state == WRESP);
    assign io_slave.bresp   = bresp;
    assign io_slave.bid     = wr_id;
    assign io_slave.rvalid  = !reset && out_valid;
    assign io_slave.rdata   = out_beat.data;
    assign io_slave.rresp   = out_beat.resp;
    assign io_slave.rlast   = out_beat.last;
    assign io_slave.rid     = rd_id;

    assign ar_hs     = io_slave.arvalid && io_slave.arready;
    assign aw_hs     = io_slave.awvalid && io_slave.awready;
    assign pop       = io_slave.rvalid && io_slave.rready;
    // Buffer fill after this edge, counting the RAM beat that lands now
    assign occ_after = {1'b0, out_valid} + {1'b0, skid_valid} - {1'b0, pop} + {1'b0, rd_pend};

    assign wr_beat = !reset && (state == WR) && io_slave.wvalid;
    assign wr_we   = wr_beat && burst_ok(wr_burst);

    // Read issue: first beat goes out on the AR handshake itself so data is on R two cycles later
    always_comb begin
        rd_issue   = 1'b0;
        issue_addr = rd_addr;
        issue_err  = !burst_ok(rd_burst);
        issue_last = (rd_issued == {1'b0, rd_len});
        issue_incr = (rd_burst == BURST_INCR);
        if (ar_hs) begin
            rd_issue   = 1'b1;
            issue_addr = io_slave.araddr[DEPTH_LOG2+2:3];
            issue_err  = !burst_ok(io_slave.arburst);
            issue_last = (io_slave.arlen == 8'd0);
            issue_incr = (io_slave.arburst == BURST_INCR);
        end else if (!reset && (state == RD) && (rd_issued <= {1'b0, rd_len})
                     && (occ_after <= 2'd1)) begin
            rd_issue = 1'b1;
        end
    end

    // RAM port mux and beat formation; error bursts never touch the RAM
    always_comb begin
        ram_en       = wr_we || (rd_issue && !issue_err);
        ram_addr     = wr_we ? wr_addr : issue_addr;
        in_beat.data = rd_pend_err ? 64'd0 : ram_rdata;
        in_beat.resp = rd_pend_err ? RESP_SLVERR : RESP_OKAY;
        in_beat.last = rd_pend_last;
    end

    vmem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clock(clock),
        .en   (ram_en),
        .we   (wr_we),
        .be   (io_slave.wstrb),
        .addr (ram_addr),
        .wdata(io_slave.wdata),
        .rdata(ram_rdata)
    );

    // Controller state and round-robin priority between AR and AW
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            prio_rd <= 1'b1;
        end else begin
            if (ar_hs) begin
                prio_rd <= 1'b0;
            end else if (aw_hs) begin
                prio_rd <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        state <= RD;
                    end else if (aw_hs) begin
                        state <= WR;
                    end
                end
                RD:      if (pop && out_beat.last) state <= IDLE;
                WR:      if (wr_beat && io_slave.wlast) state <= WRESP;
                WRESP:   if (io_slave.bready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read context: latch AR, track issued beats and the beat in flight from the RAM
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_id        <= '0;
            rd_len       <= '0;
            rd_burst     <= BURST_FIXED;
            rd_addr      <= '0;
            rd_issued    <= '0;
            rd_pend      <= 1'b0;
            rd_pend_err  <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            rd_pend      <= rd_issue;
            rd_pend_err  <= issue_err;
            rd_pend_last <= issue_last;
            if (ar_hs) begin
                rd_id    <= io_slave.arid;
                rd_len   <= io_slave.arlen;
                rd_burst <= io_slave.arburst;
            end
            if (rd_issue) begin
                rd_issued <= ar_hs ? 9'd1 : rd_issued + 9'd1;
                rd_addr   <= issue_addr + {{(DEPTH_LOG2-1){1'b0}}, issue_incr};
            end
        end
    end

    // R output buffer: pop from out, refill from skid, then from the arriving RAM beat
    always_ff @(posedge clock) begin
        if (reset) begin
            out_beat   <= '0;
            skid_beat  <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                out_beat   <= skid_beat;
                skid_valid <= rd_pend;
                if (rd_pend) skid_beat <= in_beat;
            end else begin
                out_valid <= rd_pend;
                if (rd_pend) out_beat <= in_beat;
            end
        end else if (rd_pend) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_beat  <= in_beat;
            end else begin
                skid_valid <= 1'b1;
                skid_beat  <= in_beat;
            end
        end
    end

    // Write context: latch AW, count beats, and settle the response on wlast
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_id      <= '0;
            wr_len     <= '0;
            wr_burst   <= BURST_FIXED;
            wr_addr    <= '0;
            wr_cnt     <= '0;
            wr_overrun <= 1'b0;
            bresp      <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                wr_id      <= io_slave.awid;
                wr_len     <= io_slave.awlen;
                wr_burst   <= io_slave.awburst;
                wr_addr    <= io_slave.awaddr[DEPTH_LOG2+2:3];
                wr_cnt     <= '0;
                wr_overrun <= 1'b0;
            end
            if (wr_beat) begin
                wr_cnt <= wr_cnt + 9'd1;
                if (wr_burst == BURST_INCR) begin
                    wr_addr <= wr_addr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                end
                // Sticky so a long overrun cannot wrap the counter back to a match
                if (!io_slave.wlast && (wr_cnt == {1'b0, wr_len})) begin
                    wr_overrun <= 1'b1;
                end
                if (io_slave.wlast) begin
                    bresp <= (!burst_ok(wr_burst) || wr_overrun || (wr_cnt != {1'b0, wr_len}))
                             ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

endmodule

// File: tb/tb_vmem_axi_slave.sv
// Directed and randomized bench for vmem_axi_slave against a word-array memory model.
module tb_vmem_axi_slave;

    localparam int DEPTH_LOG2 = 18;
    localparam int ID_W       = 4;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] mem_model [int unsigned];

    vmem_axi_if #(.ID_W(ID_W)) io_slave ();

    vmem_axi_slave #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .ID_W      (ID_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .io_slave(io_slave)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 3) % DEPTH;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        io_slave.awvalid = 0; io_slave.awaddr = 0; io_slave.awid = 0; io_slave.awlen = 0;
        io_slave.awsize = 3; io_slave.awburst = 1;
        io_slave.arvalid = 0; io_slave.araddr = 0; io_slave.arid = 0; io_slave.arlen = 0;
        io_slave.arsize = 3; io_slave.arburst = 1;
        io_slave.wvalid = 0; io_slave.wdata = 0; io_slave.wstrb = 0; io_slave.wlast = 0;
        io_slave.bready = 0; io_slave.rready = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        io_slave.arvalid = 1; io_slave.awvalid = 1; io_slave.wvalid = 1;
        io_slave.rready = 1; io_slave.bready = 1;
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_arready", 64'(io_slave.arready), 0);
        check("rst_awready", 64'(io_slave.awready), 0);
        check("rst_wready", 64'(io_slave.wready), 0);
        check("rst_rvalid", 64'(io_slave.rvalid), 0);
        check("rst_bvalid", 64'(io_slave.bvalid), 0);
        check("rst_rdata", io_slave.rdata, 0);
        check("rst_rmeta", 64'({io_slave.rresp, io_slave.rlast, io_slave.rid}), 0);
        check("rst_bmeta", 64'({io_slave.bresp, io_slave.bid}), 0);
        @(posedge clock); #1;
        idle_inputs();
        reset = 0;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [ID_W-1:0] id, input int len,
                          input logic [1:0] burst);
        io_slave.arvalid = 1; io_slave.araddr = a; io_slave.arid = id;
        io_slave.arlen = 8'(len); io_slave.arburst = burst; io_slave.arsize = 3;
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [ID_W-1:0] id, input int len,
                          input logic [1:0] burst);
        io_slave.awvalid = 1; io_slave.awaddr = a; io_slave.awid = id;
        io_slave.awlen = 8'(len); io_slave.awburst = burst; io_slave.awsize = 3;
    endtask

    task automatic ar_wait(output int waits);
        logic got = 0;
        waits = 0;
        while (!got && waits <= 100) begin
            @(negedge clock); got = io_slave.arready;
            @(posedge clock); #1;
            if (!got) waits++;
        end
        io_slave.arvalid = 0;
        check("ar_handshake", 64'(got), 1);
    endtask

    task automatic aw_wait(output int waits);
        logic got = 0;
        waits = 0;
        while (!got && waits <= 100) begin
            @(negedge clock); got = io_slave.awready;
            @(posedge clock); #1;
            if (!got) waits++;
        end
        io_slave.awvalid = 0;
        check("aw_handshake", 64'(got), 1);
    endtask

    // rmode: 0 rready held high, 1 toggling 1,0,1,0..., 2 random
    task automatic rd_collect(input logic [31:0] a, input logic [ID_W-1:0] id, input int len,
                              input logic [1:0] burst, input int rmode, input bit check_lat);
        int beats = 0;
        int cyc = 0;
        int first = -1;
        logic prev_stall = 0;
        logic [63:0] prev_data = 0;
        logic [2+1+ID_W-1:0] prev_meta = 0;
        int unsigned w = widx(a);
        logic [63:0] exp;
        while (beats <= len && cyc < 2000) begin
            case (rmode)
                0:       io_slave.rready = 1;
                1:       io_slave.rready = (cyc % 2 == 0);
                default: io_slave.rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clock);
            cyc++;
            if (prev_stall) begin
                check("r_stall_valid", 64'(io_slave.rvalid), 1);
                check("r_stall_data", io_slave.rdata, prev_data);
                check("r_stall_meta", 64'({io_slave.rresp, io_slave.rlast, io_slave.rid}),
                      64'(prev_meta));
            end
            if (io_slave.rvalid && first < 0) first = cyc;
            if (io_slave.rvalid && io_slave.rready) begin
                exp = (burst > 2'd1) ? 64'd0 : mem_model[w];
                check("r_data", io_slave.rdata, exp);
                check("r_resp", 64'(io_slave.rresp), (burst > 2'd1) ? 64'd2 : 64'd0);
                check("r_last", 64'(io_slave.rlast), 64'(beats == len));
                check("r_id", 64'(io_slave.rid), 64'(id));
                beats++;
                if (burst == 2'd1) w = (w + 1) % DEPTH;
            end
            prev_stall = io_slave.rvalid && !io_slave.rready;
            prev_data  = io_slave.rdata;
            prev_meta  = {io_slave.rresp, io_slave.rlast, io_slave.rid};
            @(posedge clock); #1;
        end
        io_slave.rready = 0;
        check("r_beat_count", 64'(beats), 64'(len + 1));
        if (check_lat) check("r_first_latency", 64'(first), 64'd2);
    endtask

    // dmode: 0 beat index, 1 random, 2 dval; smode: 0 sval, 1 random non-zero
    task automatic wr_data(input logic [31:0] a, input logic [ID_W-1:0] id, input int len,
                           input logic [1:0] burst, input int nbeats, input int dmode,
                           input logic [63:0] dval, input int smode, input logic [7:0] sval);
        int unsigned w = widx(a);
        logic [63:0] d;
        logic [7:0] s;
        logic got;
        int waits;
        for (int i = 0; i < nbeats; i++) begin
            d = (dmode == 0) ? 64'(i) : (dmode == 1) ? {$urandom, $urandom} : dval;
            s = (smode == 1) ? 8'($urandom_range(1, 255)) : sval;
            io_slave.wvalid = 1; io_slave.wdata = d; io_slave.wstrb = s;
            io_slave.wlast = (i == nbeats - 1);
            got = 0; waits = 0;
            while (!got && waits <= 50) begin
                @(negedge clock); got = io_slave.wready;
                @(posedge clock); #1;
                waits++;
            end
            check("w_ready", 64'(got), 1);
            if (burst <= 2'd1) begin
                mem_model[w] = merge(mem_model.exists(w) ? mem_model[w] : 64'd0, d, s);
                if (burst == 2'd1) w = (w + 1) % DEPTH;
            end
        end
        io_slave.wvalid = 0; io_slave.wlast = 0;
        io_slave.bready = 1;
        got = 0; waits = 0;
        while (!got && waits <= 50) begin
            @(negedge clock); got = io_slave.bvalid;
            if (got) begin
                check("b_resp", 64'(io_slave.bresp),
                      (burst > 2'd1 || nbeats != len + 1) ? 64'd2 : 64'd0);
                check("b_id", 64'(io_slave.bid), 64'(id));
            end
            @(posedge clock); #1;
            if (!got) waits++;
        end
        io_slave.bready = 0;
        check("b_valid", 64'(got), 1);
        check("b_latency", 64'(waits), 0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [ID_W-1:0] id, input int len,
                            input logic [1:0] burst, input int nbeats, input int dmode,
                            input logic [63:0] dval, input int smode, input logic [7:0] sval);
        int waits;
        set_aw(a, id, len, burst);
        aw_wait(waits);
        wr_data(a, id, len, burst, nbeats, dmode, dval, smode, sval);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [ID_W-1:0] id, input int len,
                           input logic [1:0] burst, input int rmode, input bit check_lat);
        int waits;
        set_ar(a, id, len, burst);
        ar_wait(waits);
        rd_collect(a, id, len, burst, rmode, check_lat);
    endtask

    // Simultaneous AR/AW: the read must win, the write must follow straight after
    task automatic dual_pair(input logic [ID_W-1:0] rid, input logic [ID_W-1:0] wid);
        int waits;
        set_ar(32'h10, rid, 0, 2'd1);
        set_aw(32'h18, wid, 0, 2'd1);
        @(negedge clock);
        check("arb_ar_first", 64'(io_slave.arready), 1);
        check("arb_aw_blocked", 64'(io_slave.awready), 0);
        @(posedge clock); #1;
        io_slave.arvalid = 0;
        rd_collect(32'h10, rid, 0, 2'd1, 0, 1);
        aw_wait(waits);
        check("arb_aw_next", 64'(waits), 0);
        wr_data(32'h18, wid, 0, 2'd1, 1, 1, 64'd0, 0, 8'hFF);
    endtask

    initial begin
        int beats;
        int cyc;
        int waits;
        logic [31:0] ra;
        int rl;
        logic [1:0] rb;

        idle_inputs();
        do_reset();

        // Single-beat write then read back
        do_write(32'h10, 4'd3, 0, 2'd1, 1, 2, 64'h1122334455667788, 0, 8'hFF);
        do_read(32'h10, 4'd5, 0, 2'd1, 0, 1);

        // Arbitration straight out of reset; RAM content survives reset
        do_reset();
        dual_pair(4'd1, 4'd2);
        dual_pair(4'd6, 4'd7);

        // 200-beat fill and full-rate / stalled readback
        do_write(32'h0, 4'd1, 199, 2'd1, 200, 0, 64'd0, 0, 8'hFF);
        do_read(32'h0, 4'd2, 199, 2'd1, 0, 1);
        @(negedge clock);
        check("r_idle_after_burst", 64'(io_slave.rvalid), 0);
        @(posedge clock); #1;
        do_read(32'h0, 4'd9, 199, 2'd1, 1, 1);

        // Partial strobe merge
        do_write(32'h3000, 4'd4, 0, 2'd1, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 8'hFF);
        do_write(32'h3000, 4'd4, 0, 2'd1, 1, 2, 64'h0000_0000_AABB_CCDD, 0, 8'h0F);
        do_read(32'h3000, 4'd6, 0, 2'd1, 0, 0);

        // Error cases: bad read burst, short write burst, bad write burst dropped
        do_read(32'h20, 4'd7, 3, 2'd3, 2, 1);
        do_write(32'h40, 4'd8, 3, 2'd1, 3, 1, 64'd0, 1, 8'd0);
        do_read(32'h40, 4'd8, 2, 2'd1, 2, 0);
        do_write(32'h3000, 4'd9, 1, 2'd2, 2, 1, 64'd0, 0, 8'hFF);
        do_read(32'h3000, 4'd6, 0, 2'd1, 0, 0);
        do_write(32'h3000, 4'd10, 1, 2'd1, 3, 1, 64'd0, 0, 8'hFF);

        // Randomized bursts over a preset window
        do_write(32'h1000, 4'd1, 23, 2'd1, 24, 1, 64'd0, 0, 8'hFF);
        for (int k = 0; k < 6; k++) begin
            ra = 32'h1000 + ($urandom_range(0, 15) << 3);
            rl = $urandom_range(0, 7);
            rb = 2'($urandom_range(0, 1));
            do_write(ra, 4'($urandom), rl, rb, rl + 1, 1, 64'd0, 1, 8'd0);
        end
        do_read(32'h1000, 4'hC, 23, 2'd1, 2, 1);
        do_read(32'h1008, 4'hD, 4, 2'd0, 2, 1);

        // Reset in the middle of a long read
        set_ar(32'h0, 4'hA, 199, 2'd1);
        ar_wait(waits);
        io_slave.rready = 1;
        beats = 0; cyc = 0;
        while (beats < 50 && cyc < 500) begin
            @(negedge clock);
            cyc++;
            if (io_slave.rvalid) begin
                check("mid_data", io_slave.rdata, mem_model[beats]);
                beats++;
            end
            @(posedge clock); #1;
        end
        check("mid_beats", 64'(beats), 64'd50);
        reset = 1;
        @(negedge clock);
        check("mid_rst_rvalid", 64'(io_slave.rvalid), 0);
        @(posedge clock); #1;
        reset = 0;
        io_slave.rready = 0;
        @(negedge clock);
        check("mid_post_rvalid", 64'(io_slave.rvalid), 0);
        check("mid_post_arready", 64'(io_slave.arready), 1);
        @(posedge clock); #1;
        do_read(32'h50, 4'hB, 9, 2'd1, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
